// File: rtl/field_cfg_loader_pkg.sv
// Shared types and constants for the Game-of-Life field config loader.
package field_cfg_loader_pkg;

  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    CFG_1  = 2'd1,
    CFG_2  = 2'd2
  } load_cfg_req_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } fcl_state_e;

  localparam int FIELD_W_DEF = 32;
  localparam int FIELD_H_DEF = 32;

  // Galois form of x^32+x^22+x^2+x+1, right-shifting
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2F35;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/field_cfg_loader_pattern_rom.sv
// Combinational fixed-pattern ROM: (cfg, row) -> row word.
module fcl_pattern_rom
  import field_cfg_loader_pkg::*;
#(
  parameter int FIELD_W   = FIELD_W_DEF,
  parameter int FIELD_H   = FIELD_H_DEF,
  parameter int ROW_IDX_W = $clog2(FIELD_H)
) (
  input  load_cfg_req_t        cfg_i,
  input  logic [ROW_IDX_W-1:0] row_i,
  output logic [FIELD_W-1:0]   row_o
);

  localparam logic [ROW_IDX_W-1:0] MID_ROW =
    ROW_IDX_W'(FIELD_H / 2);
  localparam int BLINK_LSB = FIELD_W / 2 - 1;

  logic [31:0] word;

  always_comb begin
    word = 32'h0;
    unique case (cfg_i)
      CFG_1: begin
        if (row_i == ROW_IDX_W'(0))
          word = 32'h2;
        else if (row_i == ROW_IDX_W'(1))
          word = 32'h4;
        else if (row_i == ROW_IDX_W'(2))
          word = 32'h7;
      end
      CFG_2: begin
        if (row_i == MID_ROW)
          word = 32'h7 << BLINK_LSB;
      end
      default: word = 32'h0;
    endcase
  end

  assign row_o = word[FIELD_W-1:0];

endmodule

// File: rtl/field_cfg_loader.sv
// Loads a whole GoL field one row per accepted write.
// FCL_RAND_FILL_EN: CFG_2 rows come from a free-running LFSR.
module field_cfg_loader
  import field_cfg_loader_pkg::*;
#(
  parameter int FIELD_W   = FIELD_W_DEF,
  parameter int FIELD_H   = FIELD_H_DEF,
  parameter int ROW_IDX_W = $clog2(FIELD_H)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_go,
  input  load_cfg_req_t        i_load_cfg_req,
  input  logic                 i_row_ready,
  output logic                 o_is_loading,
  output logic                 o_row_we,
  output logic [ROW_IDX_W-1:0] o_row_idx,
  output logic [FIELD_W-1:0]   o_row_data,
  output logic                 o_load_done
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW =
    ROW_IDX_W'(FIELD_H - 1);

  fcl_state_e           state_q, state_d;
  logic [ROW_IDX_W-1:0] row_q, row_d;
  load_cfg_req_t        cfg_q, cfg_d;
  logic                 done_q, done_d;
  logic [FIELD_W-1:0]   rom_row;
  logic [FIELD_W-1:0]   pat_row;
  logic                 loading;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cfg_q   <= NO_REQ;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_go && i_load_cfg_req != NO_REQ) begin
          state_d = S_LOAD;
          row_d   = '0;
          cfg_d   = i_load_cfg_req;
        end
      end
      S_LOAD: begin
        if (i_row_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  fcl_pattern_rom #(
    .FIELD_W  (FIELD_W),
    .FIELD_H  (FIELD_H),
    .ROW_IDX_W(ROW_IDX_W)
  ) u_rom (
    .cfg_i(cfg_q),
    .row_i(row_q),
    .row_o(rom_row)
  );

`ifdef FCL_RAND_FILL_EN
  logic [31:0] lfsr_q;

  // Free-running so successive loads see different fills
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr_q <= LFSR_SEED;
    else
      lfsr_q <= lfsr_step(lfsr_q);
  end

  assign pat_row = (cfg_q == CFG_2) ?
                   lfsr_q[FIELD_W-1:0] : rom_row;
`else
  assign pat_row = rom_row;
`endif

  assign loading      = (state_q == S_LOAD);
  assign o_is_loading = loading;
  assign o_row_we     = loading;
  assign o_row_idx    = loading ? row_q : '0;
  assign o_row_data   = loading ? pat_row : '0;
  assign o_load_done  = done_q;

endmodule

// File: tb/tb_field_cfg_loader.sv
// Directed + randomized bench for field_cfg_loader (32x32).
module tb_field_cfg_loader;
  import field_cfg_loader_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_go = 1'b0;
  load_cfg_req_t i_load_cfg_req = NO_REQ;
  logic          i_row_ready = 1'b1;
  logic          o_is_loading;
  logic          o_row_we;
  logic [4:0]    o_row_idx;
  logic [31:0]   o_row_data;
  logic          o_load_done;

  int checks = 0;
  int failures = 0;
  logic [31:0] rows_seen [32];

  field_cfg_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_go          (i_go),
    .i_load_cfg_req(i_load_cfg_req),
    .i_row_ready   (i_row_ready),
    .o_is_loading  (o_is_loading),
    .o_row_we      (o_row_we),
    .o_row_idx     (o_row_idx),
    .o_row_data    (o_row_data),
    .o_load_done   (o_load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference field contents from the pattern definitions
  function automatic logic [31:0] exp_row(
    input load_cfg_req_t c, input int r);
    if (c == CFG_1) begin
      if (r == 0) return 32'h1 << 1;
      if (r == 1) return 32'h1 << 2;
      if (r == 2) return 32'h7;
    end
    if (c == CFG_2 && r == 32 / 2)
      return 32'h7 << (32 / 2 - 1);
    return 32'h0;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_loading"}, 32'(o_is_loading), 32'd0);
    chk({tag, "_we"}, 32'(o_row_we), 32'd0);
    chk({tag, "_done"}, 32'(o_load_done), 32'd0);
  endtask

  // mode 0: ready=1; 1: stall 3 at idx5; 2: random stalls;
  // 3: CFG_2 go at row 10; 4: reset at row 10
  task automatic run_load(input load_cfg_req_t c, input int mode);
    int idx = 0;
    int cyc = 0;
    int stalls = 0;
    int s5 = 0;
    bit poked = 0;
    @(negedge clk);
    i_load_cfg_req = c;
    i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    i_load_cfg_req = NO_REQ;
    while (idx < 32 && cyc < 200) begin
      i_row_ready = 1'b1;
      if (mode == 1 && idx == 5 && s5 < 3) begin
        i_row_ready = 1'b0;
        s5++;
      end
      if (mode == 2 && $urandom_range(3) == 0)
        i_row_ready = 1'b0;
      if (mode == 3 && idx == 10 && !poked) begin
        i_go = 1'b1;
        i_load_cfg_req = CFG_2;
        poked = 1;
      end
      if (mode == 4 && idx == 10) begin
        rst_n = 1'b0;
        #1;
        chk("rst_loading", 32'(o_is_loading), 32'd0);
        chk("rst_we", 32'(o_row_we), 32'd0);
        chk("rst_idx", 32'(o_row_idx), 32'd0);
        chk("rst_data", o_row_data, 32'd0);
        return;
      end
      #1;
      chk("loading", 32'(o_is_loading), 32'd1);
      chk("we", 32'(o_row_we), 32'd1);
      chk("idx", 32'(o_row_idx), 32'(idx));
`ifdef FCL_RAND_FILL_EN
      if (c != CFG_2)
`endif
      chk("data", o_row_data, exp_row(c, idx));
      chk("done_mid", 32'(o_load_done), 32'd0);
      rows_seen[idx] = o_row_data;
      @(posedge clk);
      if (i_row_ready) idx++;
      else stalls++;
      cyc++;
      @(negedge clk);
      i_go = 1'b0;
      i_load_cfg_req = NO_REQ;
    end
    i_row_ready = 1'b1;
    chk("rows", 32'(idx), 32'd32);
    chk("cycles", 32'(cyc), 32'(32 + stalls));
    chk("done", 32'(o_load_done), 32'd1);
    chk("end_loading", 32'(o_is_loading), 32'd0);
    chk("end_we", 32'(o_row_we), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(o_load_done), 32'd0);
  endtask

  initial begin
    #1;
    chk_quiet("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_quiet("idle");
      @(negedge clk);
    end

    run_load(CFG_1, 0);
    run_load(CFG_2, 0);
`ifdef FCL_RAND_FILL_EN
    begin
      int diff = 0;
      int nz = 0;
      for (int r = 0; r < 32; r++) begin
        if (rows_seen[r] != rows_seen[0]) diff++;
        if (rows_seen[r] != 32'h0) nz++;
      end
      chk("rand_not_equal", 32'(diff != 0), 32'd1);
      chk("rand_not_zero", 32'(nz != 0), 32'd1);
    end
`endif
    run_load(CFG_1, 1);

    @(negedge clk);
    i_load_cfg_req = NO_REQ;
    i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_quiet("noreq");
      @(negedge clk);
    end

    run_load(CFG_1, 3);

    run_load(CFG_1, 4);
    @(negedge clk);
    rst_n = 1'b1;
    run_load(CFG_1, 0);

    for (int k = 0; k < 4; k++) begin
      run_load(($urandom_range(1) == 0) ? CFG_1 : CFG_2, 2);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
